crc_stream_engine: RTL and testbench

//  Parametrised CRC generator/checker. Each accepted beat folds DATA_W message bits into the CRC.

---
 rtl/crc_pkg.sv | 32 +++
 rtl/crc_unroll.sv | 24 ++
 rtl/crc_stream_engine.sv | 124 ++++++++++++
 tb/tb_crc_stream_engine.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crc_pkg.sv
// Shared types and helpers for the CRC stream engine: FSM state encoding,
// width limits and the single-bit MSB-first CRC update.
package crc_pkg;

  localparam int unsigned CRC_MIN_W  = 2;
  localparam int unsigned CRC_MAX_W  = 32;
  localparam int unsigned DATA_MAX_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FINAL = 2'd2,
    ST_OUT   = 2'd3
  } crc_state_e;

  // One message bit into a CRC of width w, carried in a CRC_MAX_W-wide container.
  function automatic logic [CRC_MAX_W-1:0] crc_step_bit(
    input logic [CRC_MAX_W-1:0] crc,
    input logic                 d,
    input logic [CRC_MAX_W-1:0] poly,
    input int unsigned          w
  );
    logic [CRC_MAX_W-1:0] mask;
    logic [CRC_MAX_W-1:0] sh;
    logic                 fb;
    mask = {CRC_MAX_W{1'b1}} >> (CRC_MAX_W - w);
    fb   = d ^ crc[5'(w - 1)];
    sh   = (crc << 1) & mask;
    return fb ? (sh ^ (poly & mask)) : sh;
  endfunction

endpackage

// File: rtl/crc_unroll.sv
// Combinational DATA_W-step CRC advance; data_i[DATA_W-1] is folded in first.
module crc_unroll
  import crc_pkg::*;
#(
  parameter int unsigned      CRC_W  = 8,
  parameter int unsigned      DATA_W = 8,
  parameter logic [CRC_W-1:0] POLY   = 'h07
) (
  input  logic [CRC_W-1:0]  crc_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [CRC_W-1:0]  crc_o
);

  logic [CRC_W-1:0] acc;

  always_comb begin
    acc = crc_i;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      acc = CRC_W'(crc_step_bit(CRC_MAX_W'(acc), data_i[i], CRC_MAX_W'(POLY), CRC_W));
    end
    crc_o = acc;
  end

endmodule

// File: rtl/crc_stream_engine.sv
// Parametrised streaming CRC generator/checker with valid/ready framing.
// Optional CRC_CHECK_EN adds check_ok_o (raw remainder == RESIDUE).
module crc_stream_engine
  import crc_pkg::*;
#(
  parameter int unsigned      CRC_W   = 8,
  parameter logic [CRC_W-1:0] POLY    = 'h07,
  parameter logic [CRC_W-1:0] INIT    = '0,
  parameter logic [CRC_W-1:0] XOROUT  = '0,
  parameter int unsigned      DATA_W  = 8
`ifdef CRC_CHECK_EN
  ,
  parameter logic [CRC_W-1:0] RESIDUE = '0
`endif
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              clear_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_last_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CRC_W-1:0]  crc_out_o,
`ifdef CRC_CHECK_EN
  output logic              check_ok_o,
`endif
  output logic              busy_o
);

  crc_state_e       state_q;
  logic [CRC_W-1:0] crc_q;
  logic [CRC_W-1:0] crc_out_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;
  logic [CRC_W-1:0] seed_d;
  logic [CRC_W-1:0] step_d;
  logic             accept_d;

  // A new frame always starts from INIT, regardless of what crc_q holds.
  assign seed_d   = (state_q == ST_IDLE) ? INIT : crc_q;
  assign accept_d = in_valid_i & in_ready_q & ~clear_i;

  crc_unroll #(
    .CRC_W  (CRC_W),
    .DATA_W (DATA_W),
    .POLY   (POLY)
  ) u_unroll (
    .crc_i  (seed_d),
    .data_i (in_data_i),
    .crc_o  (step_d)
  );

`ifdef CRC_CHECK_EN
  logic check_ok_q;
  assign check_ok_o = check_ok_q;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      crc_q       <= INIT;
      crc_out_q   <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef CRC_CHECK_EN
      check_ok_q  <= 1'b0;
`endif
    end else if (clear_i) begin
      state_q     <= ST_IDLE;
      crc_q       <= INIT;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef CRC_CHECK_EN
      check_ok_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE, ST_RUN: begin
          in_ready_q <= 1'b1;
          if (accept_d) begin
            crc_q  <= step_d;
            busy_q <= 1'b1;
            if (in_last_i) begin
              state_q    <= ST_FINAL;
              in_ready_q <= 1'b0;
            end else begin
              state_q <= ST_RUN;
            end
          end
        end
        ST_FINAL: begin
          crc_out_q   <= crc_q ^ XOROUT;
`ifdef CRC_CHECK_EN
          check_ok_q  <= (crc_q == RESIDUE);
`endif
          crc_q       <= INIT;
          out_valid_q <= 1'b1;
          state_q     <= ST_OUT;
        end
        ST_OUT: begin
          if (out_ready_i) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // A beat offered during CLEAR must not look accepted to the source.
  assign in_ready_o  = in_ready_q & ~clear_i;
  assign out_valid_o = out_valid_q;
  assign crc_out_o   = crc_out_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_crc_stream_engine.sv
// Scoreboard bench for crc_stream_engine: byte-wide CRC-8, bit-serial CRC-8 and CRC-16/CCITT-FALSE.
module tb_crc_stream_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Main byte-wide CRC-8 instance
  logic       rst_n, clear, in_valid, in_last, out_ready;
  logic [7:0] in_data;
  logic       in_ready, out_valid, busy;
  logic [7:0] crc_out;
  // Bit-serial CRC-8 instance
  logic       b_valid, b_last, b_ready, b_ovalid, b_busy, b_oready;
  logic [0:0] b_data;
  logic [7:0] b_crc;
  // CRC-16 instance
  logic        w_valid, w_last, w_ready, w_ovalid, w_busy, w_oready;
  logic [7:0]  w_data;
  logic [15:0] w_crc;
`ifdef CRC_CHECK_EN
  logic check_ok, b_ok, w_ok;
  logic exp_ok_q [$];
`endif

  logic [7:0]  exp8_q  [$];
  logic [7:0]  expb_q  [$];
  logic [15:0] exp16_q [$];

  crc_stream_engine u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .clear_i(clear),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data), .in_last_i(in_last),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .crc_out_o(crc_out),
`ifdef CRC_CHECK_EN
    .check_ok_o(check_ok),
`endif
    .busy_o(busy)
  );

  crc_stream_engine #(.DATA_W(1)) u_bit (
    .clk_i(clk), .rst_n_i(rst_n), .clear_i(1'b0),
    .in_valid_i(b_valid), .in_ready_o(b_ready), .in_data_i(b_data), .in_last_i(b_last),
    .out_valid_o(b_ovalid), .out_ready_i(b_oready), .crc_out_o(b_crc),
`ifdef CRC_CHECK_EN
    .check_ok_o(b_ok),
`endif
    .busy_o(b_busy)
  );

  crc_stream_engine #(.CRC_W(16), .POLY(16'h1021), .INIT(16'hFFFF)) u_c16 (
    .clk_i(clk), .rst_n_i(rst_n), .clear_i(1'b0),
    .in_valid_i(w_valid), .in_ready_o(w_ready), .in_data_i(w_data), .in_last_i(w_last),
    .out_valid_o(w_ovalid), .out_ready_i(w_oready), .crc_out_o(w_crc),
`ifdef CRC_CHECK_EN
    .check_ok_o(w_ok),
`endif
    .busy_o(w_busy)
  );

  logic [7:0] msg [9];
  initial for (int i = 0; i < 9; i++) msg[i] = 8'h31 + 8'(i);

  // Monitors: a handshake completes at the next posedge when valid & ready hold at the negedge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp8_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_out: got %0h expected none", crc_out);
      end else begin
        chk("crc8_out", 32'(crc_out), 32'(exp8_q.pop_front()));
`ifdef CRC_CHECK_EN
        chk("check_ok", 32'(check_ok), 32'(exp_ok_q.pop_front()));
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && b_ovalid && b_oready) begin
      if (expb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_bit_out: got %0h expected none", b_crc);
      end else chk("crc8_bitserial", 32'(b_crc), 32'(expb_q.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (rst_n && w_ovalid && w_oready) begin
      if (exp16_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_c16_out: got %0h expected none", w_crc);
      end else chk("crc16_out", 32'(w_crc), 32'(exp16_q.pop_front()));
    end
  end

  task automatic push_exp(input logic [7:0] c);
    exp8_q.push_back(c);
`ifdef CRC_CHECK_EN
    exp_ok_q.push_back(c == 8'h00);
`endif
  endtask

  task automatic beat(input logic [7:0] d, input logic last);
    int t;
    t = 0;
    in_valid = 1'b1; in_data = d; in_last = last;
    @(negedge clk);
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) chk("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_msg(input int n, input bit has_tail, input logic [7:0] tail);
    for (int i = 0; i < n; i++) beat(msg[i], (i == n - 1) && !has_tail);
    if (has_tail) beat(tail, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b1;
    b_valid = 1'b0; b_last = 1'b0; b_data = '0; b_oready = 1'b1;
    w_valid = 1'b0; w_last = 1'b0; w_data = '0; w_oready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_crc_out", 32'(crc_out), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    // "123456789" with latency and handshake timing
    @(posedge clk); #1;
    push_exp(8'hF4);
    send_msg(9, 1'b0, 8'h00);
    @(negedge clk);
    chk("final_out_valid", 32'(out_valid), 32'd0);
    chk("final_in_ready", 32'(in_ready), 32'd0);
    chk("final_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("out_out_valid", 32'(out_valid), 32'd1);
    chk("out_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("post_in_ready", 32'(in_ready), 32'd1);
    chk("post_out_valid", 32'(out_valid), 32'd0);
    chk("post_busy", 32'(busy), 32'd0);

    // Single-beat frames
    @(posedge clk); #1;
    push_exp(8'h07); beat(8'h01, 1'b1);
    push_exp(8'h00); beat(8'h00, 1'b1);
    repeat (4) @(posedge clk); #1;

    // Back-pressure on the result
    out_ready = 1'b0;
    push_exp(8'hF4);
    send_msg(9, 1'b0, 8'h00);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_crc_out", 32'(crc_out), 32'hF4);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("release_in_ready", 32'(in_ready), 32'd1);
    chk("release_out_valid", 32'(out_valid), 32'd0);

    // CLEAR mid-frame, then a clean frame
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) beat(msg[i], 1'b0);
    clear = 1'b1; in_valid = 1'b1; in_data = 8'hAA;
    @(negedge clk);
    chk("clear_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1 clear = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("clear_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    push_exp(8'hF4);
    send_msg(9, 1'b0, 8'h00);
    repeat (4) @(posedge clk); #1;

    // CLEAR while a result is pending discards it
    out_ready = 1'b0;
    beat(8'h31, 1'b0); beat(8'h32, 1'b1);
    repeat (2) @(negedge clk);
    chk("pend_out_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1 clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("clear_out_valid", 32'(out_valid), 32'd0);
    chk("clear_out_busy", 32'(busy), 32'd0);

    // Asynchronous reset mid-frame
    @(posedge clk); #1;
    beat(8'h31, 1'b0); beat(8'h32, 1'b0); beat(8'h33, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_in_ready", 32'(in_ready), 32'd0);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_crc_out", 32'(crc_out), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    push_exp(8'h07); beat(8'h01, 1'b1);
    repeat (4) @(posedge clk); #1;

`ifdef CRC_CHECK_EN
    // Residue check with appended CRC
    push_exp(8'h00); send_msg(9, 1'b1, 8'hF4);
    repeat (4) @(posedge clk); #1;
    push_exp(8'h07); send_msg(9, 1'b1, 8'hF5);
    repeat (4) @(posedge clk); #1;
`endif

    // Bit-serial CRC-8
    expb_q.push_back(8'hF4);
    for (int i = 0; i < 9; i++) begin
      for (int j = 7; j >= 0; j--) begin
        int t;
        t = 0;
        b_valid = 1'b1; b_data[0] = msg[i][j]; b_last = (i == 8) && (j == 0);
        @(negedge clk);
        while (!b_ready && t < 20) begin @(negedge clk); t++; end
        if (t >= 20) chk("bit_accept_timeout", 32'(b_ready), 32'd1);
        @(posedge clk); #1;
      end
    end
    b_valid = 1'b0; b_last = 1'b0;

    // CRC-16/CCITT-FALSE
    exp16_q.push_back(16'h29B1);
    for (int i = 0; i < 9; i++) begin
      int t;
      t = 0;
      w_valid = 1'b1; w_data = msg[i]; w_last = (i == 8);
      @(negedge clk);
      while (!w_ready && t < 20) begin @(negedge clk); t++; end
      if (t >= 20) chk("c16_accept_timeout", 32'(w_ready), 32'd1);
      @(posedge clk); #1;
    end
    w_valid = 1'b0; w_last = 1'b0;

    begin
      int t;
      t = 0;
      while ((exp8_q.size() + expb_q.size() + exp16_q.size()) != 0 && t < 50) begin
        @(posedge clk);
        t++;
      end
      chk("drain_pending", 32'(exp8_q.size() + expb_q.size() + exp16_q.size()), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
